// File: rtl/mod_n_serial_checker.sv
// Serial divisibility checker: tracks (accumulated value mod DIVISOR) one bit per
// accepted clock, MSB-first or LSB-first, using only add and conditional subtract.
module mod_n_serial_checker #(
    parameter int DIVISOR   = 5,
    parameter int LSB_FIRST = 0,
    parameter int MAX_BITS  = 32,
    localparam int RW = ($clog2(DIVISOR) > 1) ? $clog2(DIVISOR) : 1,
    localparam int CW = $clog2(MAX_BITS + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          din,
    input  logic          din_valid,
    output logic          dout,
    output logic [RW-1:0] remainder,
    output logic          rem_valid,
    output logic [CW-1:0] bit_cnt,
    output logic          overflow
);

    typedef enum logic {EMPTY, ACCUM} state_t;

    localparam logic [RW:0]   DIV_EXT = (RW+1)'(DIVISOR);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BITS);
    localparam logic [RW-1:0] ONE     = RW'(1);

    state_t        state;
    logic [RW-1:0] pw;
    logic          restart;
    logic [RW-1:0] rem_base;
    logic [RW-1:0] pw_base;
    logic [RW-1:0] pw_term;
    logic [RW-1:0] rem_next;
    logic [RW-1:0] pw_next;
    logic [CW-1:0] cnt_base;
    logic          ovf_base;

    // Inputs are always < 2*DIVISOR, so a single conditional subtract is exact.
    function automatic logic [RW-1:0] mod_reduce(input logic [RW:0] x);
        logic [RW:0] y;
        y = (x >= DIV_EXT) ? (x - DIV_EXT) : x;
        return y[RW-1:0];
    endfunction

    // A bit arriving with clear (or in EMPTY) starts a fresh number from rem=0, pw=1.
    always_comb begin
        restart  = clear || (state == EMPTY);
        rem_base = restart ? '0 : remainder;
        pw_base  = restart ? ONE : pw;
        cnt_base = clear ? '0 : bit_cnt;
        ovf_base = clear ? 1'b0 : overflow;
        pw_term  = din ? pw_base : '0;
        pw_next  = mod_reduce({pw_base, 1'b0});
        if (LSB_FIRST != 0)
            rem_next = mod_reduce({1'b0, rem_base} + {1'b0, pw_term});
        else
            rem_next = mod_reduce({rem_base, din});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= EMPTY;
            remainder <= '0;
            pw        <= ONE;
            bit_cnt   <= '0;
            rem_valid <= 1'b0;
            dout      <= 1'b0;
            overflow  <= 1'b0;
        end else if (clear && !din_valid) begin
            state     <= EMPTY;
            remainder <= '0;
            pw        <= ONE;
            bit_cnt   <= '0;
            rem_valid <= 1'b0;
            dout      <= 1'b0;
            overflow  <= 1'b0;
        end else if (din_valid) begin
            state     <= ACCUM;
            remainder <= rem_next;
            pw        <= pw_next;
            rem_valid <= 1'b1;
            dout      <= (rem_next == '0);
            // Count saturates; the remainder keeps updating so the modulus stays exact.
            if (cnt_base == CNT_MAX) begin
                bit_cnt  <= cnt_base;
                overflow <= 1'b1;
            end else begin
                bit_cnt  <= cnt_base + CW'(1);
                overflow <= ovf_base;
            end
        end
    end

endmodule

// File: tb/tb_mod_n_serial_checker.sv
// Bench for mod_n_serial_checker: four configurations share one stimulus stream and
// are compared against an arithmetic reference of the accumulated value mod DIVISOR.
module tb_mod_n_serial_checker;

    logic clk = 1'b0;
    logic reset_n, clear, din, din_valid;
    always #5 clk = ~clk;

    logic [2:0] rem0, rem1, rem3;
    logic [1:0] rem2;
    logic [5:0] cnt0, cnt1;
    logic [2:0] cnt2;
    logic [3:0] cnt3;
    logic dout0, dout1, dout2, dout3;
    logic rv0, rv1, rv2, rv3;
    logic ovf0, ovf1, ovf2, ovf3;

    mod_n_serial_checker #(.DIVISOR(5), .LSB_FIRST(0), .MAX_BITS(32)) dut_msb (
        .clk(clk), .reset_n(reset_n), .clear(clear), .din(din), .din_valid(din_valid),
        .dout(dout0), .remainder(rem0), .rem_valid(rv0), .bit_cnt(cnt0), .overflow(ovf0));
    mod_n_serial_checker #(.DIVISOR(5), .LSB_FIRST(1), .MAX_BITS(32)) dut_lsb (
        .clk(clk), .reset_n(reset_n), .clear(clear), .din(din), .din_valid(din_valid),
        .dout(dout1), .remainder(rem1), .rem_valid(rv1), .bit_cnt(cnt1), .overflow(ovf1));
    mod_n_serial_checker #(.DIVISOR(3), .LSB_FIRST(0), .MAX_BITS(4)) dut_sat (
        .clk(clk), .reset_n(reset_n), .clear(clear), .din(din), .din_valid(din_valid),
        .dout(dout2), .remainder(rem2), .rem_valid(rv2), .bit_cnt(cnt2), .overflow(ovf2));
    mod_n_serial_checker #(.DIVISOR(8), .LSB_FIRST(1), .MAX_BITS(8)) dut_p2 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .din(din), .din_valid(din_valid),
        .dout(dout3), .remainder(rem3), .rem_valid(rv3), .bit_cnt(cnt3), .overflow(ovf3));

    int   o_rem[4];
    int   o_cnt[4];
    logic o_dout[4];
    logic o_rv[4];
    logic o_ovf[4];

    always_comb begin
        o_rem[0] = int'(rem0);  o_rem[1] = int'(rem1);  o_rem[2] = int'(rem2);  o_rem[3] = int'(rem3);
        o_cnt[0] = int'(cnt0);  o_cnt[1] = int'(cnt1);  o_cnt[2] = int'(cnt2);  o_cnt[3] = int'(cnt3);
        o_dout[0] = dout0; o_dout[1] = dout1; o_dout[2] = dout2; o_dout[3] = dout3;
        o_rv[0] = rv0;     o_rv[1] = rv1;     o_rv[2] = rv2;     o_rv[3] = rv3;
        o_ovf[0] = ovf0;   o_ovf[1] = ovf1;   o_ovf[2] = ovf2;   o_ovf[3] = ovf3;
    end

    int cfg_div[4] = '{5, 5, 3, 8};
    int cfg_lsb[4] = '{0, 1, 0, 1};
    int cfg_max[4] = '{32, 32, 4, 8};

    // Reference state: bits accepted in the current number and its value mod DIVISOR.
    int m_k[4];
    int m_rem[4];
    bit m_valid[4];

    int errors = 0;
    int checks = 0;

    function automatic int exp_cnt(input int i);
        return (m_k[i] > cfg_max[i]) ? cfg_max[i] : m_k[i];
    endfunction

    function automatic logic exp_ovf(input int i);
        return m_k[i] > cfg_max[i];
    endfunction

    function automatic logic exp_dout(input int i);
        return m_valid[i] && (m_rem[i] == 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_k[i] = 0;
            m_rem[i] = 0;
            m_valid[i] = 1'b0;
        end
    endtask

    task automatic model_step(input bit c, input bit v, input bit d);
        int pw;
        for (int i = 0; i < 4; i++) begin
            if (c && !v) begin
                m_k[i] = 0;
                m_rem[i] = 0;
                m_valid[i] = 1'b0;
            end else if (v) begin
                if (c) begin
                    m_k[i] = 0;
                    m_rem[i] = 0;
                end
                if (cfg_lsb[i] != 0) begin
                    pw = 1;
                    for (int j = 0; j < m_k[i]; j++) pw = (pw * 2) % cfg_div[i];
                    m_rem[i] = (m_rem[i] + int'(d) * pw) % cfg_div[i];
                end else begin
                    m_rem[i] = (m_rem[i] * 2 + int'(d)) % cfg_div[i];
                end
                m_k[i] = m_k[i] + 1;
                m_valid[i] = 1'b1;
            end
        end
    endtask

    // Drive one cycle of inputs, let the edge sample them, then settle 1 ns past it.
    task automatic step(input bit c, input bit v, input bit d);
        clear = c;
        din_valid = v;
        din = d;
        @(posedge clk);
        model_step(c, v, d);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear = 1'b0;
        din = 1'b0;
        din_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            checks += 5;
            if (o_rem[i] !== 0) begin errors++; $display("FAIL reset_rem[%0d]: got %0d expected 0", i, o_rem[i]); end
            if (o_cnt[i] !== 0) begin errors++; $display("FAIL reset_cnt[%0d]: got %0d expected 0", i, o_cnt[i]); end
            if (o_rv[i] !== 1'b0) begin errors++; $display("FAIL reset_rv[%0d]: got %b expected 0", i, o_rv[i]); end
            if (o_dout[i] !== 1'b0) begin errors++; $display("FAIL reset_dout[%0d]: got %b expected 0", i, o_dout[i]); end
            if (o_ovf[i] !== 1'b0) begin errors++; $display("FAIL reset_ovf[%0d]: got %b expected 0", i, o_ovf[i]); end
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks += 2;
            if (o_rv[i] !== 1'b0) begin errors++; $display("FAIL release_rv[%0d]: got %b expected 0", i, o_rv[i]); end
            if (o_cnt[i] !== 0) begin errors++; $display("FAIL release_cnt[%0d]: got %0d expected 0", i, o_cnt[i]); end
        end
    endtask

    task automatic test_msb_vector();
        bit bits[4] = '{1, 0, 1, 0};
        int er[4]   = '{1, 2, 0, 0};
        bit ed[4]   = '{0, 0, 1, 1};
        step(1'b1, 1'b0, 1'b0);
        for (int j = 0; j < 4; j++) begin
            step(1'b0, 1'b1, bits[j]);
            checks += 3;
            if (o_rem[0] !== er[j]) begin errors++; $display("FAIL msb_rem[%0d]: got %0d expected %0d", j, o_rem[0], er[j]); end
            if (o_dout[0] !== ed[j]) begin errors++; $display("FAIL msb_dout[%0d]: got %b expected %b", j, o_dout[0], ed[j]); end
            if (o_cnt[0] !== j + 1) begin errors++; $display("FAIL msb_cnt[%0d]: got %0d expected %0d", j, o_cnt[0], j + 1); end
        end
    endtask

    task automatic test_lsb_vector();
        bit bits[4] = '{0, 1, 0, 1};
        int er[4]   = '{0, 2, 2, 0};
        bit ed[4]   = '{1, 0, 0, 1};
        step(1'b1, 1'b0, 1'b0);
        for (int j = 0; j < 4; j++) begin
            step(1'b0, 1'b1, bits[j]);
            checks += 2;
            if (o_rem[1] !== er[j]) begin errors++; $display("FAIL lsb_rem[%0d]: got %0d expected %0d", j, o_rem[1], er[j]); end
            if (o_dout[1] !== ed[j]) begin errors++; $display("FAIL lsb_dout[%0d]: got %b expected %b", j, o_dout[1], ed[j]); end
        end
    endtask

    task automatic test_gap();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        for (int j = 0; j < 3; j++) begin
            step(1'b0, 1'b0, 1'b0);
            checks += 2;
            if (o_rem[0] !== 1) begin errors++; $display("FAIL gap_rem[%0d]: got %0d expected 1", j, o_rem[0]); end
            if (o_cnt[0] !== 1) begin errors++; $display("FAIL gap_cnt[%0d]: got %0d expected 1", j, o_cnt[0]); end
        end
        step(1'b0, 1'b1, 1'b1);
        checks += 2;
        if (o_rem[0] !== 3) begin errors++; $display("FAIL gap_rem_after: got %0d expected 3", o_rem[0]); end
        if (o_cnt[0] !== 2) begin errors++; $display("FAIL gap_cnt_after: got %0d expected 2", o_cnt[0]); end
    endtask

    task automatic test_clear_with_valid();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        checks += 1;
        if (o_rem[0] !== 3) begin errors++; $display("FAIL cwv_pre_rem: got %0d expected 3", o_rem[0]); end
        step(1'b1, 1'b1, 1'b1);
        checks += 4;
        if (o_rem[0] !== 1) begin errors++; $display("FAIL cwv_rem: got %0d expected 1", o_rem[0]); end
        if (o_cnt[0] !== 1) begin errors++; $display("FAIL cwv_cnt: got %0d expected 1", o_cnt[0]); end
        if (o_rv[0] !== 1'b1) begin errors++; $display("FAIL cwv_rv: got %b expected 1", o_rv[0]); end
        if (o_ovf[0] !== 1'b0) begin errors++; $display("FAIL cwv_ovf: got %b expected 0", o_ovf[0]); end
    endtask

    task automatic test_saturation();
        int er[5] = '{1, 0, 1, 0, 1};
        int ec[5] = '{1, 2, 3, 4, 4};
        bit eo[5] = '{0, 0, 0, 0, 1};
        step(1'b1, 1'b0, 1'b0);
        for (int j = 0; j < 5; j++) begin
            step(1'b0, 1'b1, 1'b1);
            checks += 3;
            if (o_rem[2] !== er[j]) begin errors++; $display("FAIL sat_rem[%0d]: got %0d expected %0d", j, o_rem[2], er[j]); end
            if (o_cnt[2] !== ec[j]) begin errors++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d", j, o_cnt[2], ec[j]); end
            if (o_ovf[2] !== eo[j]) begin errors++; $display("FAIL sat_ovf[%0d]: got %b expected %b", j, o_ovf[2], eo[j]); end
        end
        step(1'b0, 1'b0, 1'b0);
        checks += 1;
        if (o_ovf[2] !== 1'b1) begin errors++; $display("FAIL sat_ovf_sticky: got %b expected 1", o_ovf[2]); end
        step(1'b1, 1'b0, 1'b0);
        checks += 3;
        if (o_ovf[2] !== 1'b0) begin errors++; $display("FAIL sat_clr_ovf: got %b expected 0", o_ovf[2]); end
        if (o_cnt[2] !== 0) begin errors++; $display("FAIL sat_clr_cnt: got %0d expected 0", o_cnt[2]); end
        if (o_rv[2] !== 1'b0) begin errors++; $display("FAIL sat_clr_rv: got %b expected 0", o_rv[2]); end
    endtask

    task automatic test_async_reset();
        bit bits[3] = '{1, 0, 1};
        int er[3]   = '{1, 2, 0};
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks += 4;
            if (o_rem[i] !== 0) begin errors++; $display("FAIL areset_rem[%0d]: got %0d expected 0", i, o_rem[i]); end
            if (o_cnt[i] !== 0) begin errors++; $display("FAIL areset_cnt[%0d]: got %0d expected 0", i, o_cnt[i]); end
            if (o_rv[i] !== 1'b0) begin errors++; $display("FAIL areset_rv[%0d]: got %b expected 0", i, o_rv[i]); end
            if (o_dout[i] !== 1'b0) begin errors++; $display("FAIL areset_dout[%0d]: got %b expected 0", i, o_dout[i]); end
        end
        model_reset();
        #1;
        reset_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            step(1'b0, 1'b1, bits[j]);
            checks += 2;
            if (o_rem[0] !== er[j]) begin errors++; $display("FAIL areset_after_rem[%0d]: got %0d expected %0d", j, o_rem[0], er[j]); end
            if (o_cnt[0] !== j + 1) begin errors++; $display("FAIL areset_after_cnt[%0d]: got %0d expected %0d", j, o_cnt[0], j + 1); end
        end
    endtask

    task automatic test_random();
        bit c, v, d;
        for (int n = 0; n < 1500; n++) begin
            c = ($urandom_range(0, 79) == 0);
            v = ($urandom_range(0, 3) != 0);
            d = 1'($urandom_range(0, 1));
            step(c, v, d);
            for (int i = 0; i < 4; i++) begin
                checks += 6;
                if (o_rem[i] !== m_rem[i]) begin errors++; $display("FAIL rnd_rem[%0d] cyc %0d: got %0d expected %0d", i, n, o_rem[i], m_rem[i]); end
                if (o_cnt[i] !== exp_cnt(i)) begin errors++; $display("FAIL rnd_cnt[%0d] cyc %0d: got %0d expected %0d", i, n, o_cnt[i], exp_cnt(i)); end
                if (o_ovf[i] !== exp_ovf(i)) begin errors++; $display("FAIL rnd_ovf[%0d] cyc %0d: got %b expected %b", i, n, o_ovf[i], exp_ovf(i)); end
                if (o_rv[i] !== m_valid[i]) begin errors++; $display("FAIL rnd_rv[%0d] cyc %0d: got %b expected %b", i, n, o_rv[i], m_valid[i]); end
                if (o_dout[i] !== exp_dout(i)) begin errors++; $display("FAIL rnd_dout[%0d] cyc %0d: got %b expected %b", i, n, o_dout[i], exp_dout(i)); end
                if (o_dout[i] && !o_rv[i]) begin errors++; $display("FAIL rnd_dout_without_valid[%0d] cyc %0d: got dout=1 rv=0 expected dout=0", i, n); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_msb_vector();
        test_lsb_vector();
        test_gap();
        test_clear_with_valid();
        test_saturation();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
